// File: rtl/lcd_hex_writer.sv
// Renders two 32-bit words as 8 uppercase hex chars per row on a 16x2 HD44780 (8-bit bus).
// Optional build macro LCD_HEX_PREFIX_EN prefixes each row with "0x".
module lcd_hex_writer #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned EN_PULSE_CYC   = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] line1,
    input  logic [31:0] line2,
    input  logic        refresh,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_en,
    output logic        lcd_rw
);

    localparam int unsigned MAX_A   = (POWERUP_CYC > EN_PULSE_CYC) ? POWERUP_CYC : EN_PULSE_CYC;
    localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

`ifdef LCD_HEX_PREFIX_EN
    localparam int unsigned ROW_CHARS = 10;
`else
    localparam int unsigned ROW_CHARS = 8;
`endif
    localparam int unsigned FRAME_BYTES = 2 * (ROW_CHARS + 1);
    localparam int unsigned IW          = 5;

    localparam logic [CW:0]    POWERUP_N = (CW + 1)'(POWERUP_CYC);
    localparam logic [CW:0]    EN_N      = (CW + 1)'(EN_PULSE_CYC);
    localparam logic [CW:0]    CMD_N     = (CW + 1)'(CMD_WAIT_CYC);
    localparam logic [CW:0]    CLEAR_N   = (CW + 1)'(CLEAR_WAIT_CYC);
    localparam logic [IW-1:0]  IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]  IDX_ROW1  = IW'(ROW_CHARS + 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(FRAME_BYTES - 1);
    localparam logic [IW-1:0]  IDX_INIT3 = IW'(3);

    typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_FRAME} state_e;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;
    logic [CW:0]   wait_n;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   snap1_q, snap1_d;
    logic [31:0]   snap2_q, snap2_d;
    logic          pend_q, pend_d;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          byte_done;
    logic          start_frame;
    logic          load;
    logic [8:0]    next_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Returns {rs, data} for frame byte idx: address cmd, row-0 chars, address cmd, row-1 chars.
    function automatic logic [8:0] frame_byte(input logic [IW-1:0] idx,
                                              input logic [31:0]   w1,
                                              input logic [31:0]   w2);
        logic [IW-1:0] pos;
        logic [31:0]   w;
        logic [2:0]    digit;
        logic [3:0]    nib;
        if (idx == '0)
            return {1'b0, 8'h80};
        if (idx == IDX_ROW1)
            return {1'b0, 8'hC0};
        if (idx > IDX_ROW1) begin
            w   = w2;
            pos = idx - IDX_ROW1 - IDX_ONE;
        end else begin
            w   = w1;
            pos = idx - IDX_ONE;
        end
`ifdef LCD_HEX_PREFIX_EN
        if (pos == '0)
            return {1'b1, 8'h30};
        if (pos == IDX_ONE)
            return {1'b1, 8'h78};
        digit = 3'(pos - IW'(2));
`else
        digit = 3'(pos);
`endif
        nib = 4'(w >> {3'd7 - digit, 2'b00});
        return {1'b1, hex_char(nib)};
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign wait_n  = (!rs_q && data_q == 8'h01) ? CLEAR_N : CMD_N;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_POWERUP;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap1_q <= '0;
            snap2_q <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            pend_q  <= pend_d;
            if (load)
                {rs_q, data_q} <= next_byte;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap1_d     = snap1_q;
        snap2_d     = snap2_q;
        pend_d      = pend_q;
        byte_done   = 1'b0;
        start_frame = 1'b0;

        if (state_q == ST_FRAME && refresh)
            pend_d = 1'b1;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_inc >= POWERUP_N) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            ST_IDLE: begin
                if (refresh || pend_q || line1 != snap1_q || line2 != snap2_q) begin
                    state_d     = ST_FRAME;
                    start_frame = 1'b1;
                end
            end
            default: begin
                // Zero-length pulse or wait phases are skipped outright.
                case (phase_q)
                    PH_SETUP: begin
                        cnt_d = '0;
                        if (EN_N != '0)
                            phase_d = PH_EN;
                        else if (wait_n != '0)
                            phase_d = PH_WAIT;
                        else
                            byte_done = 1'b1;
                    end
                    PH_EN: begin
                        if (cnt_inc >= EN_N) begin
                            cnt_d = '0;
                            if (wait_n != '0)
                                phase_d = PH_WAIT;
                            else
                                byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_inc[CW-1:0];
                        end
                    end
                    default: begin
                        if (cnt_inc >= wait_n) begin
                            cnt_d     = '0;
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_inc[CW-1:0];
                        end
                    end
                endcase
            end
        endcase

        if (byte_done) begin
            phase_d = PH_SETUP;
            if (state_q == ST_INIT) begin
                if (idx_q == IDX_INIT3) begin
                    state_d     = ST_FRAME;
                    start_frame = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else if (idx_q == IDX_LAST) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end

        if (start_frame) begin
            snap1_d = line1;
            snap2_d = line2;
            pend_d  = 1'b0;
            idx_d   = '0;
            phase_d = PH_SETUP;
            cnt_d   = '0;
        end
    end

    // The byte for the next setup cycle is registered on entry so bus lines stay put until then.
    always_comb begin
        next_byte = (state_d == ST_INIT) ? {1'b0, init_cmd(idx_d[1:0])}
                                         : frame_byte(idx_d, snap1_d, snap2_d);
        load      = ((state_d == ST_INIT) || (state_d == ST_FRAME)) && (phase_d == PH_SETUP);
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        lcd_en   = (phase_q == PH_EN);
        lcd_data = data_q;
        lcd_rs   = rs_q;
        lcd_rw   = 1'b0;
    end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Scoreboard bench for lcd_hex_writer: expected bytes/timing queued at stimulus, strobes compared as they occur.
module tb_lcd_hex_writer;

    localparam int P_PWR   = 10;
    localparam int P_EN    = 2;
    localparam int P_CMD   = 3;
    localparam int P_CLR   = 7;
    localparam int PER     = 1 + P_EN + P_CMD;
    localparam int PER_CLR = 1 + P_EN + P_CLR;
    localparam int PER_GAP = PER + 1;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] line1   = '0;
    logic [31:0] line2   = '0;
    logic        refresh = 1'b0;
    logic        busy;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_en;
    logic        lcd_rw;

    always #5 clock = ~clock;

    lcd_hex_writer #(
        .POWERUP_CYC   (P_PWR),
        .EN_PULSE_CYC  (P_EN),
        .CMD_WAIT_CYC  (P_CMD),
        .CLEAR_WAIT_CYC(P_CLR)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .line1   (line1),
        .line2   (line2),
        .refresh (refresh),
        .busy    (busy),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_en  (lcd_en),
        .lcd_rw  (lcd_rw)
    );

    typedef struct {
        logic [8:0] b;
        int         per;
    } exp_t;

    typedef struct {
        logic [8:0] b_rise;
        logic [8:0] b_fall;
        int         rise;
        int         width;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic en_prev = 1'b0;
    obs_t cur;

    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor: records {rs,data} at the rising and falling edges of lcd_en.
    always @(negedge clock) begin
        if (lcd_en && !en_prev) begin
            cur.b_rise = {lcd_rs, lcd_data};
            cur.rise   = cyc;
        end
        if (!lcd_en && en_prev) begin
            cur.b_fall = {lcd_rs, lcd_data};
            cur.width  = cyc - cur.rise;
            obs_q.push_back(cur);
        end
        en_prev = lcd_en;
    end

    task automatic push_exp(input logic [8:0] b, input int per);
        exp_t e;
        e.b   = b;
        e.per = per;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_exp({1'b0, 8'h38}, 0);
        push_exp({1'b0, 8'h0C}, PER);
        push_exp({1'b0, 8'h01}, PER);
        push_exp({1'b0, 8'h06}, PER_CLR);
    endtask

    task automatic push_row(input logic [31:0] w);
        string      hx = "0123456789ABCDEF";
        logic [3:0] nib;
`ifdef LCD_HEX_PREFIX_EN
        push_exp({1'b1, 8'h30}, PER);
        push_exp({1'b1, 8'h78}, PER);
`endif
        for (int d = 0; d < 8; d++) begin
            nib = w[31 - 4 * d -: 4];
            push_exp({1'b1, hx[nib]}, PER);
        end
    endtask

    task automatic push_frame(input logic [31:0] w1, input logic [31:0] w2, input int first_per);
        push_exp({1'b0, 8'h80}, first_per);
        push_row(w1);
        push_exp({1'b0, 8'hC0}, PER);
        push_row(w2);
    endtask

    task automatic collect(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
    endtask

    task automatic test_powerup_init();
        bit   quiet = 1'b1;
        int   prev  = 0;
        exp_t e;
        obs_t o;
        push_init();
        push_frame(32'h0, 32'h0, PER);
        reset = 1'b1;
        repeat (P_PWR) begin
            @(negedge clock);
            if (lcd_en !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL powerup_quiet: got lcd_en high within %0d cycles want low", P_PWR); end
        @(negedge clock);
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL powerup_first_strobe: got %b want 1", lcd_en); end
        collect(exp_q.size(), 600);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL init_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL init_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL init_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        wait_idle(40);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_line1_change();
        int   prev = 0;
        exp_t e;
        obs_t o;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        line1 = 32'hDEAD_BEEF;
        push_frame(line1, line2, 0);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", busy); end
        collect(exp_q.size(), 400);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL line1_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL line1_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL line1_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        wait_idle(40);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL line1_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_hex_encoding();
        int   prev = 0;
        exp_t e;
        obs_t o;
        line1 = 32'h0123_4567;
        line2 = 32'h89AB_CDEF;
        push_frame(line1, line2, 0);
        collect(exp_q.size(), 400);
        wait_idle(40);
        line1 = 32'h0000_00AB;
        push_frame(line1, line2, 0);
        collect(exp_q.size(), 400);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hex_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL hex_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL hex_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        wait_idle(40);
    endtask

    task automatic test_refresh_coalesce();
        int   prev = 0;
        exp_t e;
        obs_t o;
        push_frame(line1, line2, 0);
        pulse_refresh();
        repeat (20) @(negedge clock);
        push_frame(line1, line2, PER_GAP);
        repeat (3) begin
            pulse_refresh();
            repeat (4) @(negedge clock);
        end
        collect(exp_q.size(), 600);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL coalesce_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL coalesce_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL coalesce_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        repeat (40) @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL coalesce_extra: got %0d further strobes want 0", obs_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coalesce_idle: got busy=%b want 0", busy); end
        obs_q.delete();
    endtask

    task automatic test_line2_midframe();
        int   prev = 0;
        exp_t e;
        obs_t o;
        line2 = 32'h0000_0001;
        push_frame(line1, line2, 0);
        collect(exp_q.size(), 400);
        wait_idle(40);
        repeat (3) @(negedge clock);
        push_frame(line1, 32'h0000_0001, 0);
        pulse_refresh();
        repeat (20) @(negedge clock);
        line2 = 32'h0000_0002;
        push_frame(line1, 32'h0000_0002, PER_GAP);
        collect(exp_q.size(), 800);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midframe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL midframe_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL midframe_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        wait_idle(40);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midstrobe();
        bit   quiet = 1'b1;
        int   prev  = 0;
        int   k     = 0;
        exp_t e;
        obs_t o;
        pulse_refresh();
        while (lcd_en !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL midstrobe_seen: got lcd_en=%b want 1", lcd_en); end
        #2 reset = 1'b0;
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL async_en_drop: got %b want 0", lcd_en); end
        checks++; if (busy !== 1'b1 || lcd_data !== 8'h00) begin errors++; $display("FAIL async_reset_state: got busy=%b data=%h want busy=1 data=00", busy, lcd_data); end
        @(negedge clock);
        @(negedge clock);
        exp_q.delete(); obs_q.delete();
        push_init();
        push_frame(line1, line2, PER);
        reset = 1'b1;
        repeat (P_PWR) begin
            @(negedge clock);
            if (lcd_en !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL repowerup_quiet: got lcd_en high within %0d cycles want low", P_PWR); end
        collect(exp_q.size(), 600);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reinit_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() != 0 && obs_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.b_rise !== e.b || o.b_fall !== e.b) begin errors++; $display("FAIL reinit_byte %0d: got %h/%h want %h", i, o.b_rise, o.b_fall, e.b); end
            checks++; if (o.width != P_EN || (e.per != 0 && o.rise - prev != e.per)) begin errors++; $display("FAIL reinit_timing %0d: got width=%0d period=%0d want width=%0d period=%0d", i, o.width, o.rise - prev, P_EN, e.per); end
            prev = o.rise;
        end
        exp_q.delete(); obs_q.delete();
        wait_idle(40);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reinit_busy_fall: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_powerup_init();
        test_line1_change();
        test_hex_encoding();
        test_refresh_coalesce();
        test_line2_midframe();
        test_reset_midstrobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_hex_writer.md
Name: lcd_hex_writer

Overview:
- Downstream of the processor top level; replaces the line-text path into the character LCD.
- Takes two 32-bit debug words (line 1: instruction word; line 2: selected UI value) and renders each as 8 uppercase hex characters on a 16x2 HD44780 in 8-bit mode.
- Owns power-up init, per-byte enable strobing and command wait timing.
- Redraws automatically whenever either word changes, or on an explicit refresh request.

Parameters:
- POWERUP_CYC, 750000: cycles idle after reset before the first command (15 ms at 50 MHz).
- EN_PULSE_CYC, 12: cycles lcd_en is held high per byte.
- CMD_WAIT_CYC, 2000: cycles after lcd_en falls before the next byte (40 us).
- CLEAR_WAIT_CYC, 82000: post-strobe wait used instead of CMD_WAIT_CYC after command 0x01.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous reset, active-low
- line1  in  32  word shown on row 0
- line2  in  32  word shown on row 1
- refresh  in  1  single-cycle redraw request
- busy  out  1  high during init or any frame in progress
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  0 = command, 1 = character
- lcd_en  out  1  LCD enable strobe
- lcd_rw  out  1  tied 0 (write only)

Behaviour:
- Reset (reset low, async):
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=1.
  - All counters 0, snapshots 0, pending flag cleared, FSM=POWERUP.
  - Reset asserted mid-strobe drops lcd_en immediately.
- FSM states: POWERUP -> INIT -> IDLE <-> FRAME.
  - POWERUP: count POWERUP_CYC cycles, then enter INIT.
  - INIT: issue commands 8'h38, 8'h0C, 8'h01, 8'h06 in order (rs=0). Then enter FRAME; the first frame is unconditional.
  - IDLE: busy=0. Enter FRAME next cycle if refresh=1, the pending flag is set, or line1/line2 differ from the last displayed snapshot.
  - FRAME: on entry, latch snapshot1<=line1, snapshot2<=line2 and clear pending. Byte sequence:
    - cmd 8'h80
    - 8 chars of snapshot1, nibble [31:28] first
    - cmd 8'hC0
    - 8 chars of snapshot2
    - then return to IDLE.
- Byte transfer, per byte:
  - Setup cycle: lcd_rs/lcd_data driven, lcd_en=0 (1 cycle).
  - lcd_en=1 for EN_PULSE_CYC cycles.
  - lcd_en=0 for the wait count (CLEAR_WAIT_CYC for 8'h01, else CMD_WAIT_CYC).
  - lcd_data/lcd_rs held stable from setup until the next byte's setup cycle.
  - Byte period = 1 + EN_PULSE_CYC + wait cycles.
- Hex encoding: nibble 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10).
- busy rises in the cycle after FRAME is chosen from IDLE and stays high until the cycle after the last byte's wait completes.
- refresh while busy sets the pending flag (multiple requests coalesce into one). The flag is serviced as a single frame on return to IDLE.
- Inputs that change mid-frame do not affect the frame in progress; the snapshot is used. The mismatch triggers another frame afterwards.
- refresh during POWERUP/INIT is ignored; the first frame always follows init.
- Counters are sized to hold the largest parameter. Wait counts of 0 are legal and mean no wait cycles.

Optional Feature:
- Macro LCD_HEX_PREFIX_EN.
- When defined: each row is written as "0x" (8'h30, 8'h78) followed by the 8 hex chars, giving 10 chars per row after the address command.
- When undefined: 8 chars per row, no prefix.
- Address commands (8'h80/8'hC0), timing and all other behaviour are identical in both builds.

Test Plan:
Bench parameters: POWERUP_CYC=10, EN_PULSE_CYC=2, CMD_WAIT_CYC=3, CLEAR_WAIT_CYC=7.
- Reset release, line1=32'h0000_0000, line2=32'h0000_0000 -> no lcd_en edge for 10 cycles; then strobed bytes 38,0C,01,06 (rs=0); gap after 01 is 7 cycles; then 80, eight 30s, C0, eight 30s; busy falls afterwards.
- In IDLE, change line1 to 32'hDEAD_BEEF -> frame bytes 80,44,45,41,44,42,45,45,46,C0, then line2 chars; each byte period is 6 cycles.
- refresh pulsed 3 times mid-frame, inputs unchanged -> exactly one extra frame follows, then IDLE with busy=0.
- line2 changed from 32'h1 to 32'h2 during the row-0 bytes of a frame -> current frame shows 31 as the last row-1 char; an immediate second frame shows 32.
- reset asserted while lcd_en=1 -> lcd_en=0 the same cycle (async); after release the full POWERUP+INIT sequence repeats.
- With LCD_HEX_PREFIX_EN, line1=32'h0000_00AB -> row-0 bytes 80,30,78,30,30,30,30,30,30,41,42.
